// File: rtl/uart_rx_pkg.sv
// Shared UART definitions: receiver state encoding and line-level frame constants.
package uart_rx_pkg;

    // Receiver FSM states, 3-bit encoded so the transmit side can share the numbering.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } rx_state_t;

    // Line levels that define a frame.
    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;
    localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for an asynchronous input; both flops reset to the idle line level.
module uart_sync2
    import uart_rx_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic sync_out
);

    logic meta;

    // Two back-to-back flops give the first stage a full cycle to resolve metastability.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta     <= IDLE_LEVEL;
            sync_out <= IDLE_LEVEL;
        end else begin
            meta     <= async_in;
            sync_out <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: oversampled start detection, mid-bit sampling, parity and framing checks.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned DATA_BITS  = 8,
    parameter bit          PARITY_ODD = 1'b0
) (
    input  logic                 rx_clk,
    input  logic                 rx_rst,
    input  logic                 baud_tick,
    input  logic                 serial_in,
    output logic [DATA_BITS-1:0] p_data_out,
    output logic                 data_valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 rx_busy
);

    localparam int unsigned CNT_W = $clog2(OVERSAMPLE);
    localparam int unsigned IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1  = CNT_W'(OVERSAMPLE - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

    rx_state_t            state;
    logic [CNT_W-1:0]     cnt;
    logic [IDX_W-1:0]     idx;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 par_bit;
    logic                 rxd;

    uart_sync2 u_sync (
        .clk      (rx_clk),
        .rst      (rx_rst),
        .async_in (serial_in),
        .sync_out (rxd)
    );

    assign rx_busy = (state != ST_IDLE);

    // Frame FSM: counts baud ticks to the middle of each bit, shifts data in LSB first, and
    // publishes the word with its error flags at mid stop bit so the next start edge is not missed.
    always_ff @(posedge rx_clk) begin
        if (rx_rst) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            idx        <= '0;
            shift_reg  <= '0;
            par_bit    <= 1'b0;
            p_data_out <= '0;
            data_valid <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            if (baud_tick) begin
                case (state)
                    ST_IDLE: begin
                        if (rxd == START_BIT) begin
                            state <= ST_START;
                            cnt   <= '0;
                        end
                    end
                    ST_START: begin
                        if (cnt == HALF_M1) begin
                            if (rxd == START_BIT) begin
                                state <= ST_DATA;
                                cnt   <= '0;
                                idx   <= '0;
                            end else begin
                                state <= ST_IDLE;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    ST_DATA: begin
                        if (cnt == FULL_M1) begin
                            shift_reg <= {rxd, shift_reg[DATA_BITS-1:1]};
                            cnt       <= '0;
                            if (idx == LAST_IDX) begin
                                state <= ST_PARITY;
                            end else begin
                                idx <= idx + 1'b1;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    ST_PARITY: begin
                        if (cnt == FULL_M1) begin
                            par_bit <= rxd;
                            cnt     <= '0;
                            state   <= ST_STOP;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    ST_STOP: begin
                        if (cnt == FULL_M1) begin
                            p_data_out <= shift_reg;
                            parity_err <= (par_bit != ((^shift_reg) ^ PARITY_ODD));
                            frame_err  <= (rxd != STOP_BIT);
                            data_valid <= 1'b1;
                            cnt        <= '0;
                            state      <= ST_IDLE;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed testbench for uart_rx: baud_tick every 4th clock, 64 clocks per bit at 16x oversampling.
module tb_uart_rx;

    localparam int BIT_CYCLES = 64;

    logic       rx_clk;
    logic       rx_rst;
    logic       baud_tick;
    logic       serial_in;
    logic [7:0] p_data_out;
    logic       data_valid;
    logic       parity_err;
    logic       frame_err;
    logic       rx_busy;

    int totalChecks;
    int badChecks;

    // Received words captured as {parity_err, frame_err, data}, one entry per valid cycle.
    logic [9:0] rxQueue[$];
    logic [9:0] entry;

    uart_rx #(
        .OVERSAMPLE (16),
        .DATA_BITS  (8),
        .PARITY_ODD (1'b0)
    ) dut (
        .rx_clk     (rx_clk),
        .rx_rst     (rx_rst),
        .baud_tick  (baud_tick),
        .serial_in  (serial_in),
        .p_data_out (p_data_out),
        .data_valid (data_valid),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .rx_busy    (rx_busy)
    );

    // 100 MHz clock.
    initial begin
        rx_clk = 1'b0;
        forever #5 rx_clk = ~rx_clk;
    end

    // Baud tick: one cycle high out of every four, changed on the falling edge.
    initial begin
        int tickDiv;
        tickDiv   = 0;
        baud_tick = 1'b0;
        forever begin
            @(negedge rx_clk);
            tickDiv   = (tickDiv + 1) % 4;
            baud_tick = (tickDiv == 3);
        end
    end

    // Record every cycle in which data_valid is high; a stretched pulse shows up as extra entries.
    always @(negedge rx_clk) begin
        if (rx_rst === 1'b0 && data_valid === 1'b1) begin
            rxQueue.push_back({parity_err, frame_err, p_data_out});
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        totalChecks++;
        if (observed !== expected) begin
            badChecks++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic level, input int cycles);
        serial_in = level;
        repeat (cycles) @(negedge rx_clk);
    endtask

    task automatic sendFrame(input logic [7:0] data, input logic par, input logic stp);
        applyStimulus(1'b0, BIT_CYCLES);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(data[i], BIT_CYCLES);
        end
        applyStimulus(par, BIT_CYCLES);
        applyStimulus(stp, BIT_CYCLES);
    endtask

    task automatic checkFrame(input string tag, input logic [7:0] data, input logic perr, input logic ferr);
        checkOutput({tag, "_count"}, rxQueue.size(), 1);
        if (rxQueue.size() > 0) begin
            entry = rxQueue.pop_front();
            checkOutput({tag, "_data"}, entry[7:0], data);
            checkOutput({tag, "_perr"}, entry[9], perr);
            checkOutput({tag, "_ferr"}, entry[8], ferr);
        end
        rxQueue.delete();
    endtask

    initial begin
        totalChecks = 0;
        badChecks   = 0;
        serial_in   = 1'b1;
        rx_rst      = 1'b1;
        repeat (6) @(negedge rx_clk);
        checkOutput("rst_data", p_data_out, 8'h00);
        checkOutput("rst_valid", data_valid, 1'b0);
        checkOutput("rst_perr", parity_err, 1'b0);
        checkOutput("rst_ferr", frame_err, 1'b0);
        checkOutput("rst_busy", rx_busy, 1'b0);
        rx_rst = 1'b0;
        applyStimulus(1'b1, 2 * BIT_CYCLES);

        $display("[TB] clean frame 0xA5");
        sendFrame(8'hA5, 1'b0, 1'b1);
        applyStimulus(1'b1, BIT_CYCLES);
        checkFrame("a5", 8'hA5, 1'b0, 1'b0);
        checkOutput("a5_busy_after", rx_busy, 1'b0);

        $display("[TB] parity error frame 0x01");
        sendFrame(8'h01, 1'b0, 1'b1);
        applyStimulus(1'b1, BIT_CYCLES);
        checkFrame("p01", 8'h01, 1'b1, 1'b0);

        $display("[TB] framing error frame 0x3C");
        sendFrame(8'h3C, 1'b0, 1'b0);
        applyStimulus(1'b1, 12 * BIT_CYCLES);
        checkFrame("f3c", 8'h3C, 1'b0, 1'b1);
        checkOutput("f3c_busy_after", rx_busy, 1'b0);

        $display("[TB] four-tick glitch");
        applyStimulus(1'b0, 10);
        checkOutput("glitch_busy_hi", rx_busy, 1'b1);
        applyStimulus(1'b0, 6);
        applyStimulus(1'b1, 32);
        checkOutput("glitch_busy_lo", rx_busy, 1'b0);
        applyStimulus(1'b1, 12 * BIT_CYCLES);
        checkOutput("glitch_no_valid", rxQueue.size(), 0);

        $display("[TB] back-to-back 0x55 and 0xFF");
        sendFrame(8'h55, 1'b0, 1'b1);
        sendFrame(8'hFF, 1'b0, 1'b1);
        applyStimulus(1'b1, BIT_CYCLES);
        checkOutput("b2b_count", rxQueue.size(), 2);
        if (rxQueue.size() == 2) begin
            entry = rxQueue.pop_front();
            checkOutput("b2b_first", entry, {2'b00, 8'h55});
            entry = rxQueue.pop_front();
            checkOutput("b2b_second", entry, {2'b00, 8'hFF});
        end
        rxQueue.delete();

        $display("[TB] reset during data bit 3");
        applyStimulus(1'b0, BIT_CYCLES);
        applyStimulus(1'b1, BIT_CYCLES);
        applyStimulus(1'b1, BIT_CYCLES);
        applyStimulus(1'b0, BIT_CYCLES);
        applyStimulus(1'b0, BIT_CYCLES / 2);
        checkOutput("abort_busy_before", rx_busy, 1'b1);
        rx_rst    = 1'b1;
        serial_in = 1'b1;
        @(negedge rx_clk);
        rx_rst = 1'b0;
        checkOutput("abort_data", p_data_out, 8'h00);
        checkOutput("abort_valid", data_valid, 1'b0);
        checkOutput("abort_perr", parity_err, 1'b0);
        checkOutput("abort_ferr", frame_err, 1'b0);
        checkOutput("abort_busy", rx_busy, 1'b0);
        applyStimulus(1'b1, 12 * BIT_CYCLES);
        checkOutput("abort_no_valid", rxQueue.size(), 0);
        sendFrame(8'h81, 1'b0, 1'b1);
        applyStimulus(1'b1, BIT_CYCLES);
        checkFrame("r81", 8'h81, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
